// File: rtl/mc_cpu_core_if.sv
// Bus bundle for mc_cpu_core: instruction fetch port and data memory port,
// each stalled by its own busywait input.
interface mc_cpu_core_if #(
  parameter int DATA_W = 8
);
  logic [31:0]       PC;
  logic [31:0]       INSTRUCTION;
  logic              INSTR_BUSYWAIT;
  logic              READ_MEMORY;
  logic              WRITE_MEMORY;
  logic [DATA_W-1:0] ADDRESS;
  logic [DATA_W-1:0] WRITEDATA;
  logic [DATA_W-1:0] READDATA;
  logic              BUSYWAIT;
  logic              HALTED;

  modport master (
    output PC, READ_MEMORY, WRITE_MEMORY, ADDRESS, WRITEDATA, HALTED,
    input  INSTRUCTION, INSTR_BUSYWAIT, READDATA, BUSYWAIT
  );

  modport slave (
    input  PC, READ_MEMORY, WRITE_MEMORY, ADDRESS, WRITEDATA, HALTED,
    output INSTRUCTION, INSTR_BUSYWAIT, READDATA, BUSYWAIT
  );
endinterface

// File: rtl/mc_cpu_core.sv
// Multi-cycle FETCH/EXEC/MEM core; ALU/branch 2 cycles, load/store 3 + BUSYWAIT cycles, fetch stalls on INSTR_BUSYWAIT.
// ILLEGAL_TRAP_EN: an undefined opcode parks the core in HALT until reset; otherwise it is a NOP.
module mc_cpu_core #(
  parameter int          DATA_W    = 8,
  parameter int          REG_COUNT = 8,
  parameter logic [31:0] RESET_PC  = 32'h0
) (
  input logic           CLK,
  input logic           RESET_N,
  mc_cpu_core_if.master bus
);
  localparam int          IDX_W = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;
  localparam logic [31:0] DW    = 32'(DATA_W);

  localparam logic [7:0] OP_LOADI = 8'h00, OP_MOV = 8'h01, OP_ADD = 8'h02, OP_SUB = 8'h03,
                         OP_AND   = 8'h04, OP_OR  = 8'h05, OP_J   = 8'h06, OP_BEQ = 8'h07,
                         OP_BNE   = 8'h08, OP_MULT = 8'h09, OP_SLL = 8'h0A, OP_SRL = 8'h0B,
                         OP_SRA   = 8'h0C, OP_ROR = 8'h0D, OP_LWD = 8'h0E, OP_LWI = 8'h0F,
                         OP_SWD   = 8'h10, OP_SWI = 8'h11;

  typedef enum logic [1:0] {
    S_FETCH,
    S_EXEC,
    S_MEM
`ifdef ILLEGAL_TRAP_EN
    , S_HALT
`endif
  } state_t;

  state_t            r_state, w_next_state;
  logic [31:0]       r_pc, r_ir, w_pc_next;
  logic [DATA_W-1:0] r_regs [REG_COUNT];
  logic [DATA_W-1:0] r_address, r_writedata;
  logic              r_read, r_write;

  logic [7:0]        w_op, w_imm, w_off;
  logic [IDX_W-1:0]  w_rd, w_rs1, w_rs2;
  logic [DATA_W-1:0] w_opa, w_rs2v, w_opb, w_alu, w_reg_wdat;
  logic [31:0]       w_amt, w_sra_amt, w_ror_amt, w_pc4, w_target;
  logic              w_use_imm, w_is_reg_op, w_is_load, w_is_store, w_taken;
  logic              w_ir_load, w_reg_we, w_mem_start, w_mem_done;
  logic              w_unused;

  assign w_op  = r_ir[31:24];
  assign w_off = r_ir[23:16];
  assign w_imm = r_ir[7:0];
  assign w_rd  = r_ir[16 +: IDX_W];
  assign w_rs1 = r_ir[8 +: IDX_W];
  assign w_rs2 = r_ir[0 +: IDX_W];
  assign w_unused = ^r_ir[15:8];

  assign w_opa     = r_regs[w_rs1];
  assign w_rs2v    = r_regs[w_rs2];
  assign w_use_imm = (w_op == OP_LOADI) || (w_op == OP_LWI) || (w_op == OP_SWI) ||
                     ((w_op >= OP_SLL) && (w_op <= OP_ROR));
  assign w_opb     = w_use_imm ? DATA_W'(w_imm) : w_rs2v;

  assign w_is_reg_op = (w_op <= OP_OR) || ((w_op >= OP_MULT) && (w_op <= OP_ROR));
  assign w_is_load   = (w_op == OP_LWD) || (w_op == OP_LWI);
  assign w_is_store  = (w_op == OP_SWD) || (w_op == OP_SWI);

  // Shift amount is the raw 8-bit immediate, interpreted against DATA_W
  assign w_amt     = {24'd0, w_imm};
  assign w_sra_amt = (w_amt > DW - 32'd1) ? (DW - 32'd1) : w_amt;
  assign w_ror_amt = w_amt % DW;

  always_comb begin
    w_alu = w_opb;
    case (w_op)
      OP_ADD:  w_alu = w_opa + w_opb;
      OP_SUB:  w_alu = w_opa - w_opb;
      OP_AND:  w_alu = w_opa & w_opb;
      OP_OR:   w_alu = w_opa | w_opb;
      OP_MULT: w_alu = w_opa * w_opb;
      OP_SLL:  w_alu = (w_amt >= DW) ? '0 : (w_opa << w_amt);
      OP_SRL:  w_alu = (w_amt >= DW) ? '0 : (w_opa >> w_amt);
      OP_SRA:  w_alu = $signed(w_opa) >>> w_sra_amt;
      OP_ROR:  w_alu = (w_opa >> w_ror_amt) | (w_opa << (DW - w_ror_amt));
      default: ;
    endcase
  end

  assign w_pc4    = r_pc + 32'd4;
  assign w_target = w_pc4 + {{22{w_off[7]}}, w_off, 2'b00};
  assign w_taken  = (w_op == OP_J) ||
                    ((w_op == OP_BEQ) && (w_opa == w_rs2v)) ||
                    ((w_op == OP_BNE) && (w_opa != w_rs2v));

`ifdef ILLEGAL_TRAP_EN
  logic w_is_defined;
  assign w_is_defined = (w_op <= OP_SWI);
`endif

  always_comb begin
    w_next_state = r_state;
    w_pc_next    = r_pc;
    w_ir_load    = 1'b0;
    w_reg_we     = 1'b0;
    w_reg_wdat   = w_alu;
    w_mem_start  = 1'b0;
    w_mem_done   = 1'b0;
    case (r_state)
      S_FETCH: begin
        if (!bus.INSTR_BUSYWAIT) begin
          w_ir_load    = 1'b1;
          w_next_state = S_EXEC;
        end
      end
      S_EXEC: begin
        if (w_is_load || w_is_store) begin
          w_mem_start  = 1'b1;
          w_next_state = S_MEM;
        end
`ifdef ILLEGAL_TRAP_EN
        else if (!w_is_defined) begin
          w_next_state = S_HALT;
        end
`endif
        else begin
          w_reg_we     = w_is_reg_op;
          w_pc_next    = w_taken ? w_target : w_pc4;
          w_next_state = S_FETCH;
        end
      end
      S_MEM: begin
        if (!bus.BUSYWAIT) begin
          w_mem_done   = 1'b1;
          w_reg_we     = r_read;
          w_reg_wdat   = bus.READDATA;
          w_pc_next    = w_pc4;
          w_next_state = S_FETCH;
        end
      end
      default: w_next_state = r_state;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) r_state <= S_FETCH;
    else          r_state <= w_next_state;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_pc        <= RESET_PC;
      r_ir        <= '0;
      r_address   <= '0;
      r_writedata <= '0;
      r_read      <= 1'b0;
      r_write     <= 1'b0;
      for (int i = 0; i < REG_COUNT; i++) r_regs[i] <= '0;
    end else begin
      r_pc <= w_pc_next;
      if (w_ir_load) r_ir <= bus.INSTRUCTION;
      if (w_reg_we)  r_regs[w_rd] <= w_reg_wdat;
      if (w_mem_start) begin
        r_address   <= w_alu;
        r_writedata <= w_opa;
        r_read      <= w_is_load;
        r_write     <= w_is_store;
      end else if (w_mem_done) begin
        r_read  <= 1'b0;
        r_write <= 1'b0;
      end
    end
  end

  assign bus.PC           = r_pc;
  assign bus.READ_MEMORY  = r_read;
  assign bus.WRITE_MEMORY = r_write;
  assign bus.ADDRESS      = r_address;
  assign bus.WRITEDATA    = r_writedata;
`ifdef ILLEGAL_TRAP_EN
  assign bus.HALTED = (r_state == S_HALT);
`else
  assign bus.HALTED = 1'b0;
`endif
endmodule

// File: tb/tb_mc_cpu_core.sv
// Bench for mc_cpu_core: program memory, stalling data memory and a store scoreboard.
module tb_mc_cpu_core;
  localparam logic [7:0] OP_LOADI = 8'h00, OP_MOV = 8'h01, OP_ADD = 8'h02, OP_SUB = 8'h03,
                         OP_AND   = 8'h04, OP_OR  = 8'h05, OP_J   = 8'h06, OP_BEQ = 8'h07,
                         OP_BNE   = 8'h08, OP_MULT = 8'h09, OP_SLL = 8'h0A, OP_SRL = 8'h0B,
                         OP_SRA   = 8'h0C, OP_ROR = 8'h0D, OP_LWD = 8'h0E, OP_LWI = 8'h0F,
                         OP_SWD   = 8'h10, OP_SWI = 8'h11;
  localparam logic [31:0] PARK = 32'h06FF0000;

  logic CLK = 1'b0;
  logic RESET_N = 1'b0;
  logic instr_stall = 1'b0;
  logic [31:0] imem [256];
  logic [7:0]  dmem [256];
  logic [15:0] exp_q [$];
  int checks = 0;
  int errors = 0;
  int mem_wait = 0;
  int busy_cnt = 0;
  int hi_cnt = 0;

  always #5 CLK = ~CLK;

  mc_cpu_core_if #(.DATA_W(8)) bus ();

  mc_cpu_core #(.DATA_W(8), .REG_COUNT(8), .RESET_PC(32'h40)) dut (
    .CLK(CLK),
    .RESET_N(RESET_N),
    .bus(bus.master)
  );

  assign bus.INSTRUCTION    = imem[bus.PC[9:2]];
  assign bus.INSTR_BUSYWAIT = instr_stall;

  function automatic logic [31:0] ins(input logic [7:0] op, input logic [7:0] rd,
                                      input logic [7:0] rs1, input logic [7:0] rs2);
    return {op, rd, rs1, rs2};
  endfunction

  task automatic put(input logic [31:0] a, input logic [31:0] w);
    imem[a[9:2]] = w;
  endtask

  // One cycle: wait for the falling edge, then act as the data memory.
  task automatic tick();
    logic [15:0] e;
    @(negedge CLK);
    if (bus.READ_MEMORY || bus.WRITE_MEMORY) begin
      hi_cnt++;
      if (busy_cnt < mem_wait) begin
        bus.BUSYWAIT = 1'b1;
        busy_cnt++;
      end else begin
        bus.BUSYWAIT = 1'b0;
        checks++;
        if (hi_cnt != mem_wait + 1) begin
          errors++;
          $display("FAIL req_cycles got=%0d exp=%0d", hi_cnt, mem_wait + 1);
        end
        if (bus.WRITE_MEMORY) begin
          dmem[bus.ADDRESS] = bus.WRITEDATA;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL store_unexpected addr=%h data=%h", bus.ADDRESS, bus.WRITEDATA);
          end else begin
            e = exp_q.pop_front();
            if ({bus.ADDRESS, bus.WRITEDATA} !== e) begin
              errors++;
              $display("FAIL store addr/data got=%h/%h exp=%h/%h",
                       bus.ADDRESS, bus.WRITEDATA, e[15:8], e[7:0]);
            end
          end
        end else begin
          bus.READDATA = dmem[bus.ADDRESS];
        end
      end
    end else begin
      busy_cnt = 0;
      hi_cnt = 0;
      bus.BUSYWAIT = 1'b0;
    end
  endtask

  task automatic do_reset();
    RESET_N = 1'b0;
    instr_stall = 1'b0;
    bus.BUSYWAIT = 1'b0;
    bus.READDATA = '0;
    mem_wait = 0;
    busy_cnt = 0;
    hi_cnt = 0;
    exp_q.delete();
    for (int i = 0; i < 256; i++) begin
      imem[i] = PARK;
      dmem[i] = 8'h00;
    end
    @(negedge CLK);
  endtask

  task automatic check_pc(input string name, input logic [31:0] exp);
    checks++;
    if (bus.PC !== exp) begin
      errors++;
      $display("FAIL %s pc got=%h exp=%h", name, bus.PC, exp);
    end
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s stores_missing got=%0d exp=0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    do_reset();
    check_pc("reset", 32'h40);
    checks++;
    if ({bus.READ_MEMORY, bus.WRITE_MEMORY, bus.HALTED} !== 3'b000) begin
      errors++;
      $display("FAIL reset_outputs got=%b exp=000", {bus.READ_MEMORY, bus.WRITE_MEMORY, bus.HALTED});
    end
  endtask

  task automatic test_reset_mid();
    bit seen = 0;
    do_reset();
    put(32'h40, ins(OP_LOADI, 8'd1, 8'd0, 8'h33));
    put(32'h44, ins(OP_SWI, 8'd0, 8'd1, 8'h30));
    mem_wait = 10;
    RESET_N = 1'b1;
    for (int k = 0; k < 12 && !seen; k++) begin
      tick();
      if (bus.WRITE_MEMORY) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL reset_mid_no_store got=0 exp=1");
    end
    @(posedge CLK);
    #2 RESET_N = 1'b0;
    #1;
    checks++;
    if (bus.WRITE_MEMORY !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_wr got=%b exp=0", bus.WRITE_MEMORY);
    end
    check_pc("reset_mid", 32'h40);
    // Registers must come back cleared: store r1 straight after reset.
    do_reset();
    put(32'h40, ins(OP_SWI, 8'd0, 8'd1, 8'h31));
    exp_q.push_back({8'h31, 8'h00});
    RESET_N = 1'b1;
    repeat (8) tick();
    check_drained("reset_regs");
  endtask

  task automatic test_fetch_stall();
    do_reset();
    put(32'h40, ins(OP_LOADI, 8'd1, 8'd0, 8'h01));
    instr_stall = 1'b1;
    RESET_N = 1'b1;
    repeat (4) tick();
    check_pc("fetch_stall_hold", 32'h40);
    instr_stall = 1'b0;
    repeat (2) tick();
    check_pc("fetch_stall_go", 32'h44);
  endtask

  task automatic test_alu();
    do_reset();
    put(32'h40, ins(OP_LOADI, 8'd1, 8'd0, 8'h05));
    put(32'h44, ins(OP_LOADI, 8'd2, 8'd0, 8'h03));
    put(32'h48, ins(OP_SUB,   8'd3, 8'd1, 8'd2));
    put(32'h4C, ins(OP_MULT,  8'd4, 8'd1, 8'd2));
    put(32'h50, ins(OP_SWI,   8'd0, 8'd3, 8'h00));
    put(32'h54, ins(OP_SWI,   8'd0, 8'd4, 8'h01));
    exp_q.push_back({8'h00, 8'h02});
    exp_q.push_back({8'h01, 8'h0F});
    RESET_N = 1'b1;
    repeat (7) tick();
    check_pc("alu_7cyc", 32'h4C);
    tick();
    check_pc("alu_8cyc", 32'h50);
    repeat (12) tick();
    check_drained("alu");
  endtask

  task automatic test_logic();
    do_reset();
    put(32'h40, ins(OP_LOADI, 8'd1, 8'd0, 8'hF0));
    put(32'h44, ins(OP_LOADI, 8'd2, 8'd0, 8'h3C));
    put(32'h48, ins(OP_AND,   8'd3, 8'd1, 8'd2));
    put(32'h4C, ins(OP_OR,    8'd4, 8'd1, 8'd2));
    put(32'h50, ins(OP_ADD,   8'd5, 8'd1, 8'd2));
    put(32'h54, ins(OP_MOV,   8'd6, 8'd0, 8'd1));
    put(32'h58, ins(OP_SUB,   8'd7, 8'd2, 8'd1));
    for (int i = 0; i < 6; i++)
      put(32'h5C + 32'(4 * i), ins(OP_SWI, 8'd0, 8'(i == 5 ? 0 : i + 3), 8'(8'h10 + i)));
    exp_q.push_back({8'h10, 8'h30});
    exp_q.push_back({8'h11, 8'hFC});
    exp_q.push_back({8'h12, 8'h2C});
    exp_q.push_back({8'h13, 8'hF0});
    exp_q.push_back({8'h14, 8'h4C});
    exp_q.push_back({8'h15, 8'h00});
    RESET_N = 1'b1;
    repeat (40) tick();
    check_drained("logic");
  endtask

  task automatic test_shift();
    do_reset();
    put(32'h40, ins(OP_LOADI, 8'd1, 8'd0, 8'h81));
    put(32'h44, ins(OP_SRA,   8'd2, 8'd1, 8'd1));
    put(32'h48, ins(OP_ROR,   8'd3, 8'd1, 8'd1));
    put(32'h4C, ins(OP_SLL,   8'd4, 8'd1, 8'd9));
    put(32'h50, ins(OP_SRL,   8'd5, 8'd1, 8'd1));
    put(32'h54, ins(OP_ROR,   8'd6, 8'd1, 8'd9));
    put(32'h58, ins(OP_SRA,   8'd7, 8'd1, 8'd20));
    for (int i = 0; i < 6; i++)
      put(32'h5C + 32'(4 * i), ins(OP_SWI, 8'd0, 8'(i + 2), 8'(i + 2)));
    exp_q.push_back({8'h02, 8'hC0});
    exp_q.push_back({8'h03, 8'hC0});
    exp_q.push_back({8'h04, 8'h00});
    exp_q.push_back({8'h05, 8'h40});
    exp_q.push_back({8'h06, 8'hC0});
    exp_q.push_back({8'h07, 8'hFF});
    RESET_N = 1'b1;
    repeat (40) tick();
    check_drained("shift");
  endtask

  task automatic test_branch();
    logic [7:0]  br_op  [4] = '{OP_BEQ, OP_BNE, OP_BNE, OP_BEQ};
    logic [7:0]  r2_val [4] = '{8'd7, 8'd7, 8'd6, 8'd6};
    logic [31:0] exp_pc [4] = '{32'h0C, 32'h14, 32'h0C, 32'h14};
    for (int i = 0; i < 4; i++) begin
      do_reset();
      put(32'h40, ins(OP_LOADI, 8'd1, 8'd0, 8'd7));
      put(32'h44, ins(OP_LOADI, 8'd2, 8'd0, r2_val[i]));
      put(32'h48, ins(OP_J,     8'hF1, 8'd0, 8'd0));
      put(32'h10, ins(br_op[i], 8'hFE, 8'd1, 8'd2));
      RESET_N = 1'b1;
      repeat (6) tick();
      check_pc("jump", 32'h10);
      repeat (2) tick();
      check_pc($sformatf("branch%0d", i), exp_pc[i]);
    end
    do_reset();
    put(32'h40, ins(OP_J, 8'h80, 8'd0, 8'd0));
    RESET_N = 1'b1;
    repeat (2) tick();
    check_pc("pc_wrap", 32'hFFFFFE44);
  endtask

  task automatic test_mem();
    do_reset();
    put(32'h40, ins(OP_LOADI, 8'd1, 8'd0, 8'h5A));
    put(32'h44, ins(OP_SWI,   8'd0, 8'd1, 8'h20));
    put(32'h48, ins(OP_LWI,   8'd5, 8'd0, 8'h20));
    put(32'h4C, ins(OP_LOADI, 8'd2, 8'd0, 8'h21));
    put(32'h50, ins(OP_SWD,   8'd0, 8'd5, 8'd2));
    exp_q.push_back({8'h20, 8'h5A});
    exp_q.push_back({8'h21, 8'h5A});
    mem_wait = 3;
    RESET_N = 1'b1;
    repeat (7) tick();
    check_pc("store_stall", 32'h44);
    tick();
    check_pc("store_done", 32'h48);
    repeat (22) tick();
    check_pc("mem_end", 32'h54);
    check_drained("mem");
  endtask

  task automatic test_illegal();
    do_reset();
    put(32'h40, ins(OP_LOADI, 8'd1, 8'd0, 8'h09));
    put(32'h44, 32'hFF000000);
    put(32'h48, ins(OP_SWI, 8'd0, 8'd1, 8'h40));
`ifndef ILLEGAL_TRAP_EN
    exp_q.push_back({8'h40, 8'h09});
`endif
    RESET_N = 1'b1;
    repeat (4) tick();
`ifdef ILLEGAL_TRAP_EN
    check_pc("illegal_hold", 32'h44);
    repeat (8) tick();
    check_pc("illegal_hold_late", 32'h44);
    checks++;
    if (bus.HALTED !== 1'b1) begin
      errors++;
      $display("FAIL halted got=%b exp=1", bus.HALTED);
    end
`else
    check_pc("illegal_nop", 32'h48);
    checks++;
    if (bus.HALTED !== 1'b0) begin
      errors++;
      $display("FAIL halted got=%b exp=0", bus.HALTED);
    end
    repeat (8) tick();
`endif
    check_drained("illegal");
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_fetch_stall();
    test_alu();
    test_logic();
    test_shift();
    test_branch();
    test_mem();
    test_illegal();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mc_cpu_core.md
Name: mc_cpu_core

Overview:
- Parametrised multi-cycle successor of the single-cycle 8-bit core. Same 32-bit ISA and encoding; data width and register count are generic.
- An explicit FSM sequences FETCH/EXEC/MEM and handshakes with the instruction and data memories through busywait.
- Sits between the instruction cache and the data cache at top level.
- Register file, ALU and branch logic are internal.

Parameters:
- DATA_W, 8, datapath/register/data-address width (8..32).
- REG_COUNT, 8, number of registers (power of 2, 2..256); index = low log2(REG_COUNT) bits of a field.
- RESET_PC, 32'h0, PC value after reset.

Ports:
- CLK  in  1  clock, rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- PC  out  32  instruction address.
- INSTRUCTION  in  32  fetched word; valid when INSTR_BUSYWAIT=0.
- INSTR_BUSYWAIT  in  1  instruction memory stall.
- READ_MEMORY  out  1  data read request.
- WRITE_MEMORY  out  1  data write request.
- ADDRESS  out  DATA_W  data address.
- WRITEDATA  out  DATA_W  store data.
- READDATA  in  DATA_W  load data.
- BUSYWAIT  in  1  data memory stall.
- HALTED  out  1  core stopped on illegal opcode (tied 0 unless ILLEGAL_TRAP_EN).

Behaviour:
- Clocking: one clock (CLK); reset asynchronous, active-low (RESET_N).
- Reset (async, immediate): PC=RESET_PC, state=FETCH, all registers 0, READ_MEMORY=WRITE_MEMORY=0, HALTED=0, IR=0.
- Encoding: op=[31:24], rd/offset=[23:16], rs1=[15:8], rs2/imm=[7:0]. imm is zero-extended to DATA_W; offset is sign-extended.
- Opcodes 0x00..0x11: loadi, mov, add, sub, and, or, j, beq, bne, mult, sll, srl, sra, ror, lwd, lwi, swd, swi.
- FETCH:
  - On a posedge with INSTR_BUSYWAIT=0, latch IR and go to EXEC.
  - Otherwise hold; PC stable.
- EXEC (one cycle), ALU result computed from rs1 (op A) and rs2 or imm (op B):
  - Register ops write rd at the exiting edge.
  - Non-memory ops: PC <= PC+4, or branch target; next state FETCH.
  - Memory ops: latch address (ALU forward of op B) and store data (rs1); go to MEM; PC unchanged.
- MEM:
  - READ_MEMORY (lwd/lwi) or WRITE_MEMORY (swd/swi) is high for the whole state, registered, asserted from the EXEC→MEM edge.
  - Completion = first posedge in MEM with BUSYWAIT=0. At that edge: loads write READDATA to rd, request drops, PC <= PC+4, state FETCH.
  - Memory must raise BUSYWAIT within the first MEM cycle if it needs more.
- Latency: ALU/branch = 2 cycles with no stalls; load/store = 3 cycles + BUSYWAIT cycles.
- Arithmetic: all results are truncated to DATA_W.
  - sub = rs1 − rs2 (two's complement).
  - mult = low DATA_W bits of the product.
  - sll/srl with amount ≥ DATA_W give 0.
  - sra uses amount saturated to DATA_W−1.
  - ror uses amount mod DATA_W.
- Branches:
  - target = PC+4 + (sext(offset)<<2).
  - j: always taken. beq: taken if rs1==rs2. bne: taken if rs1!=rs2.
  - PC wraps modulo 2^32.
- Register writes take effect at the edge; same-register read in the following EXEC sees the new value.
- Undefined opcode: treated as NOP (PC+4) unless the optional feature is enabled.
- Reset mid-MEM or mid-stall: requests drop asynchronously; no register write occurs.
- No register is hardwired to zero.

Optional Feature:
- Macro: ILLEGAL_TRAP_EN.
- Defined: an undefined opcode in EXEC moves to HALT.
  - In HALT: HALTED=1, PC frozen at the faulting instruction, no register or memory writes.
  - Exit only by reset.
- Undefined: no HALT state; undefined opcode = NOP; HALTED constant 0.

Test Plan:
- Reset with RESET_PC=0x40 → PC=0x40, HALTED=0, requests 0. Assert RESET_N low mid-cycle → outputs reset before the next edge.
- loadi r1,5; loadi r2,3; sub r3,r1,r2; mult r4,r1,r2 (DATA_W=8) → r3=2, r4=15. Each instruction takes exactly 2 cycles.
- DATA_W=8: loadi r1,0x81; sra r2,r1,1; ror r3,r1,1; sll r4,r1,9 → r2=0xC0, r3=0xC0, r4=0x00.
- beq with r1==r2 at PC=0x10, offset=0xFE → PC=0x0C. bne on the same operands → PC=0x14.
- swi r1→0x20 then lwi r5←0x20, with BUSYWAIT high 3 cycles each:
  - WRITE_MEMORY high 4 cycles, ADDRESS=0x20, WRITEDATA=r1.
  - r5=r1 after completion; PC advances only at completion.
- Opcode 0xFF: with ILLEGAL_TRAP_EN → HALTED=1, PC held. Without it → PC+4, execution continues.
